jk_ubus_slave_mem: RTL and testbench

- Memory-backed UBUS slave responder that terminates UBUS transfers.
- Decodes the address phase, inserts wait states, writes bytes into a flop array, returns read bytes, and flags out-of-range bursts with error.
- Sits on the slave side of the bus, in place of a passive passthrough, as the responding end of the jk_ubus master/slave interface pair.

---
 rtl/jk_ubus_slave_mem.sv | 146 ++++++++++++++
 tb/tb_jk_ubus_slave_mem.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jk_ubus_slave_mem.sv
// Memory-backed UBUS slave: decodes the address phase, inserts wait states, and serves byte bursts from a flop array.
// Optional bip protocol checking is built when JK_UBUS_SLV_BIP_CHECK_EN is defined.
module jk_ubus_slave_mem #(
   parameter int                ADDR_W      = 16,
   parameter int                DATA_W      = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
   parameter int                MEM_DEPTH   = 256,
   parameter int                WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        size,
   input  logic              read,
   input  logic              write,
   input  logic              bip,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              wait_state,
   output logic              error,
   output logic              proto_err
);

   localparam int              AW      = $clog2(MEM_DEPTH);
   localparam logic [3:0]      WC_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [ADDR_W:0] LIMIT   = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(MEM_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

   state_t            r_state, w_nxt_state;
   logic [2:0]        r_k, r_len_m1, w_len_m1;
   logic              r_rd, r_bad;
   logic [AW-1:0]     r_off, w_ptr;
   logic [3:0]        r_wcnt;
   logic [ADDR_W:0]   w_end;
   logic              w_accept, w_in_range, w_last;
   logic              w_nxt_bad, w_nxt_rd, w_nxt_oe, w_nxt_wait, w_nxt_err;
   logic              r_data_oe, r_wait, r_err;
   logic [DATA_W-1:0] r_mem [MEM_DEPTH];

   assign w_accept   = read ^ write;
   assign w_len_m1   = 3'((4'd1 << size) - 4'd1);
   // One extra bit so a burst running past the top of the address space is caught as out of range.
   assign w_end      = {1'b0, addr} + (ADDR_W+1)'(w_len_m1);
   assign w_in_range = (addr >= BASE_ADDR) && (w_end <= LIMIT);
   assign w_ptr      = r_off + AW'(r_k);
   assign w_last     = (r_k == r_len_m1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_nxt_state;
   end

   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (WAIT_CYCLES > 0) w_nxt_state = S_WAIT;
               else                 w_nxt_state = S_BEAT;
            end
         end
         S_WAIT: begin
            if (r_wcnt == WC_LAST) w_nxt_state = S_BEAT;
         end
         S_BEAT: begin
            if (w_last)                w_nxt_state = S_IDLE;
            else if (WAIT_CYCLES > 0)  w_nxt_state = S_WAIT;
            else                       w_nxt_state = S_BEAT;
         end
         default: w_nxt_state = S_IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      w_nxt_bad  = (r_state == S_IDLE) ? !w_in_range : r_bad;
      w_nxt_rd   = (r_state == S_IDLE) ? read : r_rd;
      w_nxt_wait = (w_nxt_state == S_WAIT);
      w_nxt_err  = (w_nxt_state == S_BEAT) && w_nxt_bad;
      w_nxt_oe   = (w_nxt_state == S_BEAT) && w_nxt_rd && !w_nxt_bad;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_k       <= '0;
         r_len_m1  <= '0;
         r_rd      <= 1'b0;
         r_bad     <= 1'b0;
         r_off     <= '0;
         r_wcnt    <= '0;
         r_data_oe <= 1'b0;
         r_wait    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_data_oe <= w_nxt_oe;
         r_wait    <= w_nxt_wait;
         r_err     <= w_nxt_err;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_k      <= '0;
                  r_len_m1 <= w_len_m1;
                  r_rd     <= read;
                  r_bad    <= !w_in_range;
                  r_off    <= AW'(addr - BASE_ADDR);
                  r_wcnt   <= '0;
               end
            end
            S_WAIT: begin
               r_wcnt <= (r_wcnt == WC_LAST) ? 4'd0 : r_wcnt + 4'd1;
            end
            S_BEAT: begin
               r_k    <= r_k + 3'd1;
               r_wcnt <= '0;
            end
            default: r_wcnt <= '0;
         endcase
      end
   end

   // Storage is deliberately not reset; completed writes survive a reset.
   always_ff @(posedge clk) begin
      if (r_state == S_BEAT && !r_rd && !r_bad) r_mem[w_ptr] <= data_in;
   end

   assign data_out   = r_data_oe ? r_mem[w_ptr] : '0;
   assign data_oe    = r_data_oe;
   assign wait_state = r_wait;
   assign error      = r_err;

`ifdef JK_UBUS_SLV_BIP_CHECK_EN
   logic r_proto_err;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                   r_proto_err <= 1'b0;
      else if (r_state == S_BEAT && bip == w_last) r_proto_err <= 1'b1;
   end
   assign proto_err = r_proto_err;
`else
   logic w_unused_bip;
   assign w_unused_bip = bip;
   assign proto_err    = 1'b0;
`endif

endmodule

// File: tb/tb_jk_ubus_slave_mem.sv
// Bench for jk_ubus_slave_mem: two instances (no wait states / two wait states) driven from one stimulus thread,
// with every cycle's outputs of both instances checked by a queue-fed monitor against a burst-level model.
module tb_jk_ubus_slave_mem;

`ifdef JK_UBUS_SLV_BIP_CHECK_EN
   localparam bit BIP_CHK = 1'b1;
`else
   localparam bit BIP_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr0, addr1;
   logic [1:0]  size0, size1;
   logic        read0, read1, write0, write1, bip0, bip1;
   logic [7:0]  din0, din1, dout0, dout1;
   logic        oe0, oe1, ws0, ws1, err0, err1, pe0, pe1;

   always #5 clk = ~clk;

   jk_ubus_slave_mem u_dut0 (
      .clk(clk), .reset(reset), .addr(addr0), .size(size0), .read(read0), .write(write0),
      .bip(bip0), .data_in(din0), .data_out(dout0), .data_oe(oe0), .wait_state(ws0),
      .error(err0), .proto_err(pe0));

   jk_ubus_slave_mem #(.WAIT_CYCLES(2)) u_dut1 (
      .clk(clk), .reset(reset), .addr(addr1), .size(size1), .read(read1), .write(write1),
      .bip(bip1), .data_in(din1), .data_out(dout1), .data_oe(oe1), .wait_state(ws1),
      .error(err1), .proto_err(pe1));

   // Reference state: byte image of each memory and each sticky protocol flag.
   logic [7:0]  mem_m [2][256];
   bit          proto_m [2];
   logic [23:0] exp_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [23:0] mon_e, mon_a;

   // Monitor: every cycle with a pending expectation, compare both instances' outputs.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         mon_a = {pe1, ws1, err1, oe1, dout1, pe0, ws0, err0, oe0, dout0};
         n_checks++;
         if (mon_a !== mon_e) begin
            n_fail++;
            $display("FAIL cycle_out t=%0t actual={pe,ws,err,oe,data}x2=%h required=%h", $time, mon_a, mon_e);
         end
      end
   end

   function automatic logic [11:0] mk(input int id, input bit ws, input bit er, input bit oe, input logic [7:0] d);
      return {proto_m[id], ws, er, oe, d};
   endfunction

   // Drive one cycle on instance id (other instance idle) and queue the expected outputs for that cycle.
   task automatic step(input int id, input logic [15:0] a, input logic [1:0] sz, input logic rd,
                       input logic wr, input logic bp, input logic [7:0] din, input logic [11:0] e_act);
      addr0 = '0; size0 = '0; read0 = 1'b0; write0 = 1'b0; bip0 = 1'b0; din0 = '0;
      addr1 = '0; size1 = '0; read1 = 1'b0; write1 = 1'b0; bip1 = 1'b0; din1 = '0;
      if (id == 0) begin
         addr0 = a; size0 = sz; read0 = rd; write0 = wr; bip0 = bp; din0 = din;
         exp_q.push_back({mk(1, 0, 0, 0, 8'h00), e_act});
      end else begin
         addr1 = a; size1 = sz; read1 = rd; write1 = wr; bip1 = bp; din1 = din;
         exp_q.push_back({e_act, mk(0, 0, 0, 0, 8'h00)});
      end
      @(posedge clk);
      #1;
   endtask

   // One whole transfer. rst_beat >= 0 asserts reset during that beat; bip_bad_beat flips bip on that beat.
   task automatic burst(input int id, input bit rd, input bit wr, input int a, input int sz,
                        input logic [63:0] wdata, input int rst_beat, input int bip_bad_beat);
      int         len;
      int         wc;
      bit         bad;
      bit         oe;
      bit         bp;
      logic [7:0] d;
      logic [7:0] q;
      len = 1 << sz;
      wc  = (id == 0) ? 0 : 2;
      step(id, a[15:0], sz[1:0], rd, wr, 1'b0, 8'($urandom), mk(id, 0, 0, 0, 8'h00));
      if (rd == wr) return;
      bad = (a + len - 1) > 255;
      for (int k = 0; k < len; k++) begin
         for (int w = 0; w < wc; w++)
            step(id, 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), mk(id, 1, 0, 0, 8'h00));
         d  = wdata[8*k +: 8];
         bp = (k != len - 1) ^ (k == bip_bad_beat);
         if (k == rst_beat) begin
            reset = 1'b1;
            proto_m[0] = 1'b0;
            proto_m[1] = 1'b0;
            step(id, 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), bp, d, 12'h000);
            step(id, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
            reset = 1'b0;
            return;
         end
         oe = rd && !bad;
         q  = oe ? mem_m[id][(a + k) & 255] : 8'h00;
         step(id, 16'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), bp, d, mk(id, 0, bad, oe, q));
         if (BIP_CHK && (bp != (k != len - 1))) proto_m[id] = 1'b1;
         if (wr && !bad) mem_m[id][a + k] = d;
      end
   endtask

   int          r;
   int          sel;
   int          ra;
   int          rid;
   logic [63:0] rdat;

   initial begin
      reset = 1'b1;
      proto_m[0] = 1'b0;
      proto_m[1] = 1'b0;
      addr0 = '0; size0 = '0; read0 = 1'b0; write0 = 1'b0; bip0 = 1'b0; din0 = '0;
      addr1 = '0; size1 = '0; read1 = 1'b0; write1 = 1'b0; bip1 = 1'b0; din1 = '0;
      @(posedge clk);
      #1;
      // Outputs held at zero while reset is asserted.
      step(0, 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 12'h000);
      step(1, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 12'h000);
      reset = 1'b0;

      // Give every location a known value.
      for (int id = 0; id < 2; id++)
         for (int b = 0; b < 32; b++)
            burst(id, 1'b0, 1'b1, b * 8, 3, {$urandom, $urandom}, -1, -1);

      // Single-beat write then read with no wait states.
      burst(0, 1'b0, 1'b1, 'h10, 0, 64'hA5, -1, -1);
      burst(0, 1'b1, 1'b0, 'h10, 0, 64'h0, -1, -1);

      // Four-beat write/read with two wait states before each beat.
      burst(1, 1'b0, 1'b1, 'h20, 2, 64'h44332211, -1, -1);
      burst(1, 1'b1, 1'b0, 'h20, 2, 64'h0, -1, -1);

      // Burst running past the end of memory, then a legal single read there.
      burst(0, 1'b1, 1'b0, 'hFC, 3, 64'h0, -1, -1);
      burst(0, 1'b1, 1'b0, 'hFC, 0, 64'h0, -1, -1);
      burst(1, 1'b0, 1'b1, 'hFC, 2, {$urandom, $urandom}, -1, -1);
      burst(1, 1'b1, 1'b0, 'hFC, 2, 64'h0, -1, -1);

      // Read and write together is ignored; a following read is served.
      burst(0, 1'b1, 1'b1, 'h05, 0, 64'h0, -1, -1);
      burst(0, 1'b1, 1'b0, 'h05, 0, 64'h0, -1, -1);

      // Reset mid-write keeps earlier beats; reset mid-read drops outputs at once.
      burst(0, 1'b0, 1'b1, 'h30, 2, 64'hDDCCBBAA, 2, -1);
      burst(0, 1'b1, 1'b0, 'h30, 2, 64'h0, -1, -1);
      burst(1, 1'b1, 1'b0, 'h40, 2, 64'h0, 1, -1);
      burst(1, 1'b1, 1'b0, 'h40, 2, 64'h0, -1, -1);

      // bip dropped early on beat 0; the transfer still completes.
      burst(0, 1'b0, 1'b1, 'h60, 1, 64'h5A3C, -1, 0);
      burst(0, 1'b1, 1'b0, 'h60, 1, 64'h0, -1, -1);
      burst(1, 1'b0, 1'b1, 'h62, 0, 64'h77, -1, 0);

      // Randomized traffic, including addresses near the end of memory and of the address space.
      for (int i = 0; i < 80; i++) begin
         rid  = $urandom_range(0, 1);
         r    = $urandom_range(0, 8);
         sel  = $urandom_range(0, 3);
         ra   = (sel < 2) ? $urandom_range(0, 255) : (sel == 2) ? $urandom_range(248, 263)
                                                                : $urandom_range(65528, 65535);
         rdat = {$urandom, $urandom};
         burst(rid, (r < 4) || (r == 8), (r >= 4), ra, $urandom_range(0, 3), rdat, -1,
               ($urandom_range(0, 9) == 0) ? 0 : -1);
      end

      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
